// File: rtl/char_glyph_renderer.sv
// Scaled 8x16 digit renderer: beam position -> glyph ROM address -> serial pixel, 3-cycle latency, no backpressure.
// Define CHAR_BLINK_EN to add a 6-bit frame counter that blanks the glyph for 32 of every 64 frames.
module char_glyph_renderer #(
    parameter int unsigned X_ORIGIN   = 304,
    parameter int unsigned Y_ORIGIN   = 232,
    parameter int unsigned SCALE_LOG2 = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] inHCount,
    input  logic [9:0] inVCount,
    input  logic       inDisplayEn,
    input  logic       inHSync,
    input  logic       inVSync,
    input  logic [1:0] inDigit,
    output logic [5:0] outRomAddress,
    input  logic [7:0] inRomData,
    output logic       outPixel,
    output logic       outDisplayEn,
    output logic       outHSync,
    output logic       outVSync
);

    localparam logic [9:0]  X0    = 10'(X_ORIGIN);
    localparam logic [9:0]  Y0    = 10'(Y_ORIGIN);
    localparam logic [10:0] WIN_W = 11'(8 << SCALE_LOG2);
    localparam logic [10:0] WIN_H = 11'(16 << SCALE_LOG2);

    logic [9:0] dh;
    logic [9:0] dv;
    logic       in_win;
    logic       frame_start;
    logic [3:0] row;
    logic [2:0] col;
    logic [1:0] digit_q, digit_d;
    logic       blank_d;

    logic [5:0] addr_q;
    logic [2:0] col1_q, col2_q;
    logic       win1_q, win2_q;
    logic       en1_q, en2_q, en3_q;
    logic       hs1_q, hs2_q, hs3_q;
    logic       vs1_q, vs2_q, vs3_q;
    logic       blank1_q, blank2_q;
    logic       pix_q;

    // Offsets are taken by subtraction; the >= guard rejects beams left of / above the origin.
    assign dh          = inHCount - X0;
    assign dv          = inVCount - Y0;
    assign in_win      = (inHCount >= X0) && ({1'b0, dh} < WIN_W) &&
                         (inVCount >= Y0) && ({1'b0, dv} < WIN_H);
    assign row         = dv[SCALE_LOG2 +: 4];
    assign col         = dh[SCALE_LOG2 +: 3];
    assign frame_start = (inHCount == 10'd0) && (inVCount == 10'd0);

    // The frame-start cycle already addresses with the newly latched digit.
    assign digit_d     = frame_start ? inDigit : digit_q;

`ifdef CHAR_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_start ? frame_cnt_q + 6'd1 : frame_cnt_q;
    assign blank_d     = frame_cnt_d[5];

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q  <= '0;
            addr_q   <= '0;
            col1_q   <= '0;
            col2_q   <= '0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            en1_q    <= 1'b0;
            en2_q    <= 1'b0;
            en3_q    <= 1'b0;
            hs1_q    <= 1'b0;
            hs2_q    <= 1'b0;
            hs3_q    <= 1'b0;
            vs1_q    <= 1'b0;
            vs2_q    <= 1'b0;
            vs3_q    <= 1'b0;
            blank1_q <= 1'b0;
            blank2_q <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            addr_q   <= in_win ? {digit_d, row} : 6'h00;
            col1_q   <= col;
            win1_q   <= in_win;
            en1_q    <= inDisplayEn;
            hs1_q    <= inHSync;
            vs1_q    <= inVSync;
            blank1_q <= blank_d;

            // ROM read is in flight during this stage.
            col2_q   <= col1_q;
            win2_q   <= win1_q;
            en2_q    <= en1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            blank2_q <= blank1_q;

            pix_q    <= win2_q & en2_q & ~blank2_q & inRomData[3'd7 - col2_q];
            en3_q    <= en2_q;
            hs3_q    <= hs2_q;
            vs3_q    <= vs2_q;
        end
    end

    assign outRomAddress = addr_q;
    assign outPixel      = pix_q;
    assign outDisplayEn  = en3_q;
    assign outHSync      = hs3_q;
    assign outVSync      = vs3_q;

endmodule

// File: tb/tb_char_glyph_renderer.sv
// Directed bench for char_glyph_renderer with a behavioural registered glyph ROM and a latency scoreboard.
module tb_char_glyph_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] inHCount;
    logic [9:0] inVCount;
    logic       inDisplayEn;
    logic       inHSync;
    logic       inVSync;
    logic [1:0] inDigit;
    logic [5:0] outRomAddress;
    logic [7:0] inRomData;
    logic       outPixel;
    logic       outDisplayEn;
    logic       outHSync;
    logic       outVSync;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] m_digit;
`ifdef CHAR_BLINK_EN
    logic [5:0] m_cnt;
`endif
    logic [5:0] exp_addr_q[$];
    logic [3:0] exp_out_q[$];

    always #5 clock = ~clock;

    char_glyph_renderer dut (
        .clock        (clock),
        .reset        (reset),
        .inHCount     (inHCount),
        .inVCount     (inVCount),
        .inDisplayEn  (inDisplayEn),
        .inHSync      (inHSync),
        .inVSync      (inVSync),
        .inDigit      (inDigit),
        .outRomAddress(outRomAddress),
        .inRomData    (inRomData),
        .outPixel     (outPixel),
        .outDisplayEn (outDisplayEn),
        .outHSync     (outHSync),
        .outVSync     (outVSync)
    );

    function automatic logic [7:0] glyph_row(input logic [1:0] d, input logic [3:0] r);
        logic [127:0] t;
        case (d)
            2'd0:    t = 128'h00183878_18181818_18181818_187E0000;
            2'd1:    t = 128'h00FEC606_0C183060_C0C6FEFE_00000000;
            2'd2:    t = 128'h7CC60606_3C060606_C67C0000_00000000;
            default: t = 128'h0C1C3C6C_CCFE0C0C_0C1E0000_00000000;
        endcase
        return t[127 - 8 * int'(r) -: 8];
    endfunction

    always @(posedge clock) inRomData <= glyph_row(outRomAddress[5:4], outRomAddress[3:0]);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            inHCount    = 10'($urandom_range(0, 799));
            inVCount    = 10'($urandom_range(0, 524));
            inDisplayEn = 1'($urandom);
            inHSync     = 1'($urandom);
            inVSync     = 1'($urandom);
            inDigit     = 2'($urandom);
            @(posedge clock);
        end
        #1;
        chk("rst_addr",  8'(outRomAddress), 8'h00);
        chk("rst_pixel", 8'(outPixel), 8'h00);
        chk("rst_den",   8'(outDisplayEn), 8'h00);
        chk("rst_hsync", 8'(outHSync), 8'h00);
        chk("rst_vsync", 8'(outVSync), 8'h00);
        reset   = 1'b0;
        m_digit = 2'd0;
`ifdef CHAR_BLINK_EN
        m_cnt   = 6'd0;
`endif
        exp_addr_q.delete();
        exp_out_q.delete();
        exp_out_q.push_back(4'h0);
        exp_out_q.push_back(4'h0);
    endtask

    // One beam cycle: drive, predict, then compare the address from this cycle and outputs from two cycles back.
    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic en, input logic hs,
                        input logic vs, input logic [1:0] dig,
                        input int want_addr = -1, input int want_pix = -1);
        logic       win;
        logic [3:0] row;
        logic [2:0] col;
        logic [7:0] rb;
        logic [5:0] ea;
        logic       ep;
        logic [3:0] rec;
        inHCount = h; inVCount = v; inDisplayEn = en; inHSync = hs; inVSync = vs; inDigit = dig;
        if (h == 10'd0 && v == 10'd0) begin
            m_digit = dig;
`ifdef CHAR_BLINK_EN
            m_cnt = m_cnt + 6'd1;
`endif
        end
        win = (h >= 10'd304) && (h < 10'd320) && (v >= 10'd232) && (v < 10'd264);
        row = 4'((v - 10'd232) >> 1);
        col = 3'((h - 10'd304) >> 1);
        ea  = win ? {m_digit, row} : 6'h00;
        rb  = glyph_row(m_digit, row);
        ep  = win & en & rb[7 - int'(col)];
`ifdef CHAR_BLINK_EN
        if (m_cnt[5]) ep = 1'b0;
`endif
        if (want_addr >= 0) ea = 6'(want_addr);
        if (want_pix >= 0)  ep = want_pix[0];
        exp_addr_q.push_back(ea);
        exp_out_q.push_back({ep, en, hs, vs});
        @(posedge clock);
        #1;
        chk("addr", 8'(outRomAddress), 8'(exp_addr_q.pop_front()));
        rec = exp_out_q.pop_front();
        chk("pixel", 8'(outPixel),     8'(rec[3]));
        chk("den",   8'(outDisplayEn), 8'(rec[2]));
        chk("hsync", 8'(outHSync),     8'(rec[1]));
        chk("vsync", 8'(outVSync),     8'(rec[0]));
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // Blanking beams before any window hit keep the address at zero.
        step(10'd5,   10'd100, 1'b0, 1'b0, 1'b0, 2'd1, 'h00, 0);
        step(10'd600, 10'd240, 1'b1, 1'b0, 1'b0, 2'd1, 'h00, 0);

        // Frame start latches '2'; row 1 is 8'hFE.
        step(10'd0,   10'd0,   1'b1, 1'b0, 1'b1, 2'd1);
        step(10'd304, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h11, 1);
        step(10'd305, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h11, 1);
        step(10'd317, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h11, 1);
        step(10'd318, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h11, 0);
        step(10'd319, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h11, 0);
        step(10'd320, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h00, 0);
        step(10'd303, 10'd234, 1'b1, 1'b0, 1'b0, 2'd1, 'h00, 0);
        step(10'd304, 10'd231, 1'b1, 1'b0, 1'b0, 2'd1, 'h00, 0);
        step(10'd304, 10'd263, 1'b1, 1'b0, 1'b0, 2'd1, 'h1F, 0);
        step(10'd304, 10'd264, 1'b1, 1'b0, 1'b0, 2'd1, 'h00, 0);
        for (int h = 300; h < 324; h++) step(10'(h), 10'd241, 1'b1, 1'b0, 1'b0, 2'd1);

        // Mid-frame digit change is ignored until the next frame start.
        step(10'd100, 10'd240, 1'b1, 1'b0, 1'b0, 2'd3);
        step(10'd304, 10'd240, 1'b1, 1'b0, 1'b0, 2'd3, 'h14, 0);
        step(10'd0,   10'd0,   1'b1, 1'b0, 1'b0, 2'd3);
        step(10'd312, 10'd232, 1'b1, 1'b0, 1'b0, 2'd3, 'h30, 1);
        for (int h = 302; h < 322; h++) step(10'(h), 10'd242, 1'b1, 1'b0, 1'b0, 2'd3);

        // Sync pulses and blanking inside the window.
        step(10'd10,  10'd5,   1'b1, 1'b0, 1'b0, 2'd3);
        step(10'd11,  10'd5,   1'b1, 1'b1, 1'b0, 2'd3);
        step(10'd12,  10'd5,   1'b1, 1'b0, 1'b1, 2'd3);
        step(10'd13,  10'd5,   1'b1, 1'b0, 1'b0, 2'd3);
        step(10'd312, 10'd232, 1'b0, 1'b0, 1'b0, 2'd3, 'h30, 0);
        step(10'd313, 10'd232, 1'b0, 1'b1, 1'b1, 2'd3, 'h30, 0);
        repeat (3) step(10'd700, 10'd5, 1'b0, 1'b0, 1'b0, 2'd3);

        // Reset mid-frame: digit latch returns to '1' until a frame start.
        do_reset();
        step(10'd312, 10'd234, 1'b1, 1'b0, 1'b0, 2'd2, 'h01, 1);
        step(10'd311, 10'd234, 1'b1, 1'b0, 1'b0, 2'd2, 'h01, 1);
        step(10'd306, 10'd234, 1'b1, 1'b0, 1'b0, 2'd2, 'h01, 0);
        repeat (3) step(10'd700, 10'd5, 1'b0, 1'b0, 1'b0, 2'd2);

`ifdef CHAR_BLINK_EN
        // Frame 0 runs without a frame start; frames 1..32 each begin with one.
        do_reset();
        step(10'd310, 10'd234, 1'b1, 1'b0, 1'b0, 2'd0, 'h01, 1);
        for (int f = 1; f <= 32; f++) begin
            step(10'd0,   10'd0,   1'b1, 1'b0, 1'b0, 2'd0, 'h00, 0);
            step(10'd310, 10'd234, 1'b1, 1'b0, 1'b0, 2'd0, 'h01, (f < 32) ? 1 : 0);
        end
        repeat (3) step(10'd700, 10'd5, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
